// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin MSI bus controller between two dcaches and a single-ported RAM
module coherence_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BLK_WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][ADDR_W-1:0] daddr,
  input  logic [1:0][ADDR_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             dwait,
  output logic [1:0][ADDR_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [ADDR_W-1:0]      ramstore,
  input  logic [ADDR_W-1:0]      ramload,
  input  logic                   ramwait
);
  localparam int CW = BLK_WORDS > 1 ? $clog2(BLK_WORDS) : 1;
  typedef enum logic [2:0] {IDLE, SNOOP, C2C, MEMRD, WB, DONE} state_t;
  state_t              state_q;
  logic                r_q, rr_q, coh_q, inv_q;
  logic [CW-1:0]       cnt_q;
  logic [ADDR_W-1:0]   saddr_q;
  logic [1:0]          pend;
  logic                r_d, s, en, acc, last, snp;
  // Grant selection and word-accept qualification; the snooper is always the other core
  always_comb begin
    pend = cctrans | dREN | dWEN;
    r_d  = &pend ? rr_q : pend[1];
    s    = ~r_q;
    en   = state_q == C2C ? dWEN[s] : state_q == MEMRD ? dREN[r_q] : state_q == WB ? dWEN[r_q] : 1'b0;
    acc  = en & ~ramwait;
    last = cnt_q == CW'(BLK_WORDS - 1);
    snp  = coh_q & (state_q inside {SNOOP, C2C, MEMRD, WB});
  end
  // Transaction sequencer: grant, snoop, transfer words, then a one-cycle DONE gap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      rr_q    <= 1'b0;
      coh_q   <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      saddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|pend) begin
          r_q     <= r_d;
          coh_q   <= cctrans[r_d];
          state_q <= cctrans[r_d] ? SNOOP : dWEN[r_d] ? WB : MEMRD;
        end
        SNOOP: begin
          inv_q   <= ccwrite[r_q];
          saddr_q <= daddr[r_q];
          state_q <= ccwrite[s] ? C2C : dREN[r_q] ? MEMRD : DONE;
        end
        C2C, MEMRD, WB: if (acc) begin
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) state_q <= DONE;
        end
        DONE: begin
          cnt_q   <= '0;
          coh_q   <= 1'b0;
          rr_q    <= ~r_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Bus outputs: snoop signals live in SNOOP and held from registers during the transfer
  always_comb begin
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (snp) begin
      ccwait[s]      = 1'b1;
      ccinv[s]       = state_q == SNOOP ? ccwrite[r_q] : inv_q;
      ccsnoopaddr[s] = state_q == SNOOP ? daddr[r_q] : saddr_q;
    end
    case (state_q)
      C2C: begin
        ramWEN     = dWEN[s];
        ramaddr    = daddr[s];
        ramstore   = dstore[s];
        dload[r_q] = dstore[s];
        dwait[s]   = ~acc;
        dwait[r_q] = ~acc;
      end
      MEMRD: begin
        ramREN     = dREN[r_q];
        ramaddr    = daddr[r_q];
        dload[r_q] = ramload;
        dwait[r_q] = ~acc;
      end
      WB: begin
        ramWEN     = dWEN[r_q];
        ramaddr    = daddr[r_q];
        ramstore   = dstore[r_q];
        dwait[r_q] = ~acc;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed checks of arbitration, snooping, C2C, RAM read, write-back and reset
module tb_coherence_bus_ctrl;
  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr;
  logic [1:0]       dwait, ccwait, ccinv;
  logic             ramREN, ramWEN, ramwait;
  logic [31:0]      ramaddr, ramstore, ramload;
  int               tests = 0;
  int               fails = 0;

  coherence_bus_ctrl #(.ADDR_W(32), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
    daddr = '0; dstore = '0; ramload = 0; ramwait = 1;
  endtask

  initial begin
    nRST = 0;
    clear_in();
    tick(); tick();
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ccwait", ccwait, 2'b00);
    chk("rst_ccinv", ccinv, 2'b00);
    chk("rst_snpaddr", ccsnoopaddr, 64'h0);
    chk("rst_dload", dload, 64'h0);
    chk("rst_ram_en", {ramREN, ramWEN}, 2'b00);
    chk("rst_ram_bus", {ramaddr, ramstore}, 64'h0);
    nRST = 1;
    // core0 read miss, core1 invalid
    tick();
    cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h100;
    #1;
    chk("t1_idle_ccwait", ccwait, 2'b00);
    chk("t1_idle_dwait", dwait, 2'b11);
    tick();
    chk("t1_snoop_ccwait", ccwait, 2'b10);
    chk("t1_snoop_ccinv", ccinv, 2'b00);
    chk("t1_snoop_addr", ccsnoopaddr[1], 32'h100);
    chk("t1_snoop_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    chk("t1_rd_en", ramREN, 1'b1);
    chk("t1_rd_addr0", ramaddr, 32'h100);
    chk("t1_rd_stall0", dwait, 2'b11);
    chk("t1_rd_ccwait", ccwait, 2'b10);
    tick();
    chk("t1_rd_stall1", dwait, 2'b11);
    tick();
    ramwait = 0; ramload = 32'h1111_0000;
    #1;
    chk("t1_w0_dwait", dwait, 2'b10);
    chk("t1_w0_dload", dload[0], 32'h1111_0000);
    tick();
    daddr[0] = 32'h104; ramwait = 1;
    #1;
    chk("t1_w1_addr", ramaddr, 32'h104);
    chk("t1_w1_stall", dwait, 2'b11);
    tick(); tick();
    ramwait = 0; ramload = 32'h2222_0000;
    #1;
    chk("t1_w1_dload", dload[0], 32'h2222_0000);
    chk("t1_w1_dwait", dwait, 2'b10);
    tick();
    clear_in();
    #1;
    chk("t1_done_ccwait", ccwait, 2'b00);
    chk("t1_done_dwait", dwait, 2'b11);
    chk("t1_done_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    // core1 BusRdX, core0 holds M
    cctrans = 2'b10; dREN = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h300;
    tick();
    ccwrite = 2'b11; dWEN = 2'b01; daddr[0] = 32'h300; dstore[0] = 32'hDEAD_BEEF;
    #1;
    chk("t2_snoop_ccwait", ccwait, 2'b01);
    chk("t2_snoop_ccinv", ccinv, 2'b01);
    chk("t2_snoop_addr", ccsnoopaddr[0], 32'h300);
    chk("t2_snoop_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    ramwait = 0;
    #1;
    chk("t2_w0_ramwen", ramWEN, 1'b1);
    chk("t2_w0_ramaddr", ramaddr, 32'h300);
    chk("t2_w0_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t2_w0_dload", dload[1], 32'hDEAD_BEEF);
    chk("t2_w0_dwait", dwait, 2'b00);
    tick();
    daddr[0] = 32'h304; daddr[1] = 32'h304; dstore[0] = 32'hCAFE_F00D; ramwait = 1;
    #1;
    chk("t2_w1_stall", dwait, 2'b11);
    chk("t2_w1_ramwen", ramWEN, 1'b1);
    chk("t2_w1_snpaddr", ccsnoopaddr[0], 32'h300);
    chk("t2_w1_ccinv", ccinv, 2'b01);
    tick();
    ramwait = 0;
    #1;
    chk("t2_w1_dload", dload[1], 32'hCAFE_F00D);
    chk("t2_w1_ramstore", ramstore, 32'hCAFE_F00D);
    chk("t2_w1_ramaddr", ramaddr, 32'h304);
    chk("t2_w1_dwait", dwait, 2'b00);
    tick();
    clear_in();
    #1;
    chk("t2_done_cc", {ccwait, ccinv}, 4'b0000);
    chk("t2_done_ram", ramWEN, 1'b0);
    tick();
    // core0 upgrade only
    cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h380;
    tick();
    chk("t3_snoop_ccinv", ccinv, 2'b10);
    chk("t3_snoop_ccwait", ccwait, 2'b10);
    chk("t3_snoop_ram", {ramREN, ramWEN}, 2'b00);
    clear_in();
    tick();
    chk("t3_done_ccwait", ccwait, 2'b00);
    chk("t3_done_ram", {ramREN, ramWEN}, 2'b00);
    chk("t3_done_dwait", dwait, 2'b11);
    tick();
    // reset mid-C2C with core0 requesting, core1 in M
    cctrans = 2'b01; dREN = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h600;
    tick();
    ccwrite = 2'b11; dWEN = 2'b10; daddr[1] = 32'h600; dstore[1] = 32'h77;
    tick();
    ramwait = 0;
    #1;
    chk("t6_c2c_dwait", dwait, 2'b00);
    chk("t6_c2c_dload", dload[0], 32'h77);
    chk("t6_c2c_ccinv", ccinv, 2'b10);
    tick();
    ramwait = 1; nRST = 0;
    #1;
    chk("t6_rst_dwait", dwait, 2'b11);
    chk("t6_rst_cc", {ccwait, ccinv}, 4'b0000);
    chk("t6_rst_ram", {ramREN, ramWEN}, 2'b00);
    chk("t6_rst_dload", dload, 64'h0);
    clear_in();
    tick();
    nRST = 1;
    // both cores request together after reset: core0 first
    cctrans = 2'b11; dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
    tick();
    chk("t4_a_ccwait", ccwait, 2'b10);
    chk("t4_a_snpaddr", ccsnoopaddr[1], 32'h400);
    tick();
    ramwait = 0; ramload = 32'hA1;
    #1;
    chk("t4_a_dwait", dwait, 2'b10);
    chk("t4_a_dload0", dload[0], 32'hA1);
    chk("t4_a_ramaddr", ramaddr, 32'h400);
    tick();
    ramload = 32'hA2;
    #1;
    chk("t4_a_dload1", dload[0], 32'hA2);
    tick();
    cctrans = 2'b10; dREN = 2'b10; ramwait = 1;
    #1;
    chk("t4_a_done_ccwait", ccwait, 2'b00);
    tick(); tick();
    chk("t4_b_ccwait", ccwait, 2'b01);
    chk("t4_b_snpaddr", ccsnoopaddr[0], 32'h500);
    tick();
    ramwait = 0; ramload = 32'hB1;
    #1;
    chk("t4_b_dwait", dwait, 2'b01);
    chk("t4_b_dload0", dload[1], 32'hB1);
    tick();
    ramload = 32'hB2;
    #1;
    chk("t4_b_dload1", dload[1], 32'hB2);
    tick();
    clear_in();
    tick();
    // core1 write-back, slow RAM
    dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'h5555;
    tick();
    chk("t5_ramwen", ramWEN, 1'b1);
    chk("t5_ramaddr0", ramaddr, 32'h200);
    chk("t5_ramstore0", ramstore, 32'h5555);
    chk("t5_stall0", dwait, 2'b11);
    chk("t5_ccwait", ccwait, 2'b00);
    tick(); tick(); tick();
    ramwait = 0;
    #1;
    chk("t5_w0_dwait", dwait, 2'b01);
    tick();
    daddr[1] = 32'h204; dstore[1] = 32'h6666; ramwait = 1;
    tick(); tick();
    chk("t5_w1_held", ramWEN, 1'b1);
    chk("t5_w1_stall", dwait, 2'b11);
    tick();
    ramwait = 0;
    #1;
    chk("t5_w1_dwait", dwait, 2'b01);
    chk("t5_w1_ramstore", ramstore, 32'h6666);
    tick();
    clear_in();
    #1;
    chk("t5_done_ram", ramWEN, 1'b0);
    chk("t5_done_dwait", dwait, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
